// File: rtl/sample_fifo_if.sv
// Handshake bundle between a sample producer/consumer and sample_fifo.
// The master modport is the environment side; the slave modport is the FIFO side.
interface sample_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]         XIN;
   logic                     XIN_VALID;
   logic                     XIN_READY;
   logic [WIDTH-1:0]         XOUT;
   logic                     XOUT_VALID;
   logic                     XOUT_READY;
   logic [$clog2(DEPTH):0]   COUNT;
   logic                     OVERFLOW;

   modport master (
      output XIN, XIN_VALID, XOUT_READY,
      input  XIN_READY, XOUT, XOUT_VALID, COUNT, OVERFLOW
   );

   modport slave (
      input  XIN, XIN_VALID, XOUT_READY,
      output XIN_READY, XOUT, XOUT_VALID, COUNT, OVERFLOW
   );
endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with valid/ready on both sides,
// a sticky overflow flag for dropped samples and a synchronous flush (CLR).
module sample_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic           CLK,
   input  logic           RESET,
   input  logic           CLR,
   sample_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             overflow_r;

   logic             ready_s;
   logic             valid_s;
   logic             push_s;
   logic             pop_s;
   logic             drop_s;
   logic [WIDTH-1:0] head_s;

   // Handshake decode; a flush cycle swallows both push and pop and never flags a drop.
   always_comb begin
      ready_s = (count_r != FULL_COUNT);
      valid_s = (count_r != {CW{1'b0}});
      push_s  = bus.XIN_VALID & ready_s & ~CLR;
      pop_s   = bus.XOUT_VALID & bus.XOUT_READY & ~CLR;
      drop_s  = bus.XIN_VALID & ~ready_s & ~CLR;
      if (valid_s) begin
         head_s = mem_r[rd_ptr_r];
      end else begin
         head_s = {WIDTH{1'b0}};
      end
   end

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.XIN;
      end
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else if (CLR) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   assign bus.XIN_READY  = ready_s;
   assign bus.XOUT_VALID = valid_s;
   assign bus.XOUT       = head_s;
   assign bus.COUNT      = count_r;
   assign bus.OVERFLOW   = overflow_r;
endmodule

// File: tb/tb_sample_fifo.sv
// Directed, table-driven bench for sample_fifo (WIDTH=8, DEPTH=4) with
// hand-written sequences for streaming and mid-operation reset.
module tb_sample_fifo;
   logic clk;
   logic reset;
   logic clr;
   int   errors;
   int   checks;

   sample_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

   sample_fifo #(.WIDTH(8), .DEPTH(4)) dut (
      .CLK   (clk),
      .RESET (reset),
      .CLR   (clr),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       clr;
      logic       v;
      logic [7:0] x;
      logic       rdy;
      logic [2:0] cnt;
      logic       ov;
      logic [7:0] xo;
      logic       ir;
      logic       of;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic c, input logic v, input logic [7:0] x, input logic r,
                      input logic [2:0] cnt, input logic ov, input logic [7:0] xo,
                      input logic ir, input logic of);
      vec_t e;
      e.clr = c; e.v = v; e.x = x; e.rdy = r;
      e.cnt = cnt; e.ov = ov; e.xo = xo; e.ir = ir; e.of = of;
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] cnt, input logic ov,
                          input logic [7:0] xo, input logic ir, input logic of);
      chk({tag, ".COUNT"},      32'(bus.COUNT),      32'(cnt));
      chk({tag, ".XOUT_VALID"}, 32'(bus.XOUT_VALID), 32'(ov));
      chk({tag, ".XOUT"},       32'(bus.XOUT),       32'(xo));
      chk({tag, ".XIN_READY"},  32'(bus.XIN_READY),  32'(ir));
      chk({tag, ".OVERFLOW"},   32'(bus.OVERFLOW),   32'(of));
   endtask

   task automatic drive(input logic c, input logic v, input logic [7:0] x, input logic r);
      clr            = c;
      bus.XIN_VALID  = v;
      bus.XIN        = x;
      bus.XOUT_READY = r;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);

      // clr, v, x, rdy  ->  COUNT, XOUT_VALID, XOUT, XIN_READY, OVERFLOW
      add(1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'h11, 1'b1, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 8'h01, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'h02, 1'b0, 3'd2, 1'b1, 8'h01, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'h03, 1'b0, 3'd3, 1'b1, 8'h01, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'h04, 1'b0, 3'd4, 1'b1, 8'h01, 1'b0, 1'b0);
      add(1'b0, 1'b1, 8'h05, 1'b0, 3'd4, 1'b1, 8'h01, 1'b0, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h02, 1'b1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h03, 1'b1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h04, 1'b1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1);
      add(1'b0, 1'b1, 8'hB0, 1'b0, 3'd1, 1'b1, 8'hB0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 8'hB1, 1'b0, 3'd2, 1'b1, 8'hB0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 8'hB2, 1'b0, 3'd3, 1'b1, 8'hB0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 8'hB3, 1'b0, 3'd4, 1'b1, 8'hB0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'hB4, 1'b1, 3'd3, 1'b1, 8'hB1, 1'b1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'hB2, 1'b1, 1'b1);
      add(1'b1, 1'b1, 8'hC0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'hC1, 1'b0, 3'd1, 1'b1, 8'hC1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'hC2, 1'b0, 3'd2, 1'b1, 8'hC1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'hC3, 1'b0, 3'd3, 1'b1, 8'hC1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 8'hC4, 1'b0, 3'd4, 1'b1, 8'hC1, 1'b0, 1'b0);
      add(1'b1, 1'b1, 8'hC5, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
      add(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Reset values with a clock edge seen while reset is held.
      @(posedge clk);
      #1;
      chk_all("reset", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].v, vecs[i].x, vecs[i].rdy);
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].xo,
                 vecs[i].ir, vecs[i].of);
      end

      // Streaming: each sample appears one edge after its push, COUNT stays at 1.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b1);
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d.XOUT", i),  32'(bus.XOUT),  32'(8'hA0 + 8'(i)));
         chk($sformatf("stream%0d.COUNT", i), 32'(bus.COUNT), 32'd1);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      chk_all("stream_drain", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Mid-operation asynchronous reset with three entries stored.
      drive(1'b0, 1'b1, 8'hD0, 1'b0);
      @(posedge clk);
      drive(1'b0, 1'b1, 8'hD1, 1'b0);
      @(posedge clk);
      drive(1'b0, 1'b1, 8'hD2, 1'b0);
      @(posedge clk);
      #1;
      chk("prereset.COUNT", 32'(bus.COUNT), 32'd3);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk_all("async_reset", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 8'hEE, 1'b1);
      @(posedge clk);
      #1;
      chk("reset_push_lost.COUNT", 32'(bus.COUNT), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 1'b1, 8'h55, 1'b0);
      @(posedge clk);
      #1;
      chk_all("post_reset_55", 3'd1, 1'b1, 8'h55, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 8'h66, 1'b0);
      @(posedge clk);
      #1;
      chk_all("post_reset_66", 3'd2, 1'b1, 8'h55, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      chk_all("post_reset_pop", 3'd1, 1'b1, 8'h66, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  the asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port CLR  input  1  the synchronous flush request, active-high.
REQ-006 The block SHALL have port XIN  input  WIDTH  the sample data from the upstream stage.
REQ-007 The block SHALL have port XIN_VALID  input  1  the upstream flag stating that XIN holds a sample.
REQ-008 The block SHALL have port XIN_READY  output  1  the flag stating that the FIFO can accept a sample.
REQ-009 The block SHALL have port XOUT  output  WIDTH  the oldest stored sample (head of the FIFO).
REQ-010 The block SHALL have port XOUT_VALID  output  1  the flag stating that XOUT holds a stored sample.
REQ-011 The block SHALL have port XOUT_READY  input  1  the downstream flag accepting the sample on XOUT.
REQ-012 The block SHALL have port COUNT  output  log2(DEPTH)+1  the number of stored entries, 0..DEPTH.
REQ-013 The block SHALL have port OVERFLOW  output  1  a sticky flag marking that a sample was dropped.

Function
REQ-014 A push SHALL occur at a CLK rising edge when XIN_VALID=1 and XIN_READY=1; XIN is then written at the write pointer.
REQ-015 A pop SHALL occur at a CLK rising edge when XOUT_VALID=1 and XOUT_READY=1; the read pointer then advances.
REQ-016 XIN_READY SHALL be combinationally equal to (COUNT < DEPTH); it SHALL NOT depend on XOUT_READY.
REQ-017 XOUT_VALID SHALL equal (COUNT != 0).
REQ-018 XOUT SHALL present the head entry in first-word-fall-through mode.
REQ-019 A sample pushed into an empty FIFO SHALL appear on XOUT with XOUT_VALID=1 directly after that edge, with 1-cycle latency.
REQ-020 On each edge, COUNT SHALL be updated to +1 for a push alone, -1 for a pop alone, and unchanged for a simultaneous push and pop or for neither.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH, from DEPTH-1 to 0.
REQ-022 When full and a pop occurs, no push SHALL be accepted in the same cycle, because XIN_READY=0.
REQ-023 XIN_VALID=1 with XIN_READY=0 at an edge SHALL drop the sample, leave the FIFO contents unchanged, and set OVERFLOW=1.
REQ-024 OVERFLOW SHALL remain at 1 until CLR or reset.
REQ-025 CLR=1 at an edge SHALL set COUNT=0, set both pointers to 0, and set OVERFLOW=0.
REQ-026 A push or pop in the same cycle as CLR=1 SHALL be ignored, and that push SHALL NOT set OVERFLOW.
REQ-027 Sample data SHALL pass through unmodified: no width change, no sign extension.

Reset
REQ-028 While RESET=0, the block SHALL immediately, without waiting for a CLK edge, set COUNT=0, set both pointers to 0, and set OVERFLOW=0.
REQ-029 During reset, the outputs SHALL read XOUT_VALID=0, XIN_READY=1 and XOUT=0.
REQ-030 Storage array contents need not be reset, but XOUT SHALL read 0 whenever XOUT_VALID=0.
REQ-031 Assertion of RESET mid-operation SHALL discard all stored samples.
REQ-032 Any push or pop presented during the cycle in which RESET is asserted SHALL be lost.
REQ-033 The first push SHALL be accepted at the first rising edge after RESET returns to 1.

Verification
REQ-034 Reset a 4-deep FIFO, push 0x11; after the edge, the bench SHALL observe XOUT=0x11, XOUT_VALID=1 and COUNT=1.
REQ-035 Push 0x01, 0x02, 0x03, 0x04 with XOUT_READY=0, then present 0x05; the bench SHALL observe COUNT=4, XIN_READY=0 and OVERFLOW=1, then pops SHALL return 0x01..0x04 with 0x05 absent.
REQ-036 Stream 10 samples 0xA0..0xA9 with XIN_VALID=1 and XOUT_READY=1 every cycle; the bench SHALL observe outputs in order, each one cycle after its push, COUNT never above 1, and pointers wrapping past 3.
REQ-037 Fill the FIFO to full, then assert XIN_VALID and XOUT_READY together; the bench SHALL observe one pop only, COUNT=3, and XIN_READY returning to 1.
REQ-038 With COUNT=2 and OVERFLOW=1, assert CLR together with a push; after the edge, the bench SHALL observe COUNT=0, OVERFLOW=0, XOUT_VALID=0 and XOUT=0.
REQ-039 With COUNT=3, drive RESET=0 between clock edges; the bench SHALL observe COUNT=0 and XOUT_VALID=0 before the next edge, and after release, 0x55 pushed SHALL emerge first.
